// File: rtl/mem_fifo_arb.sv
// rtl/mem_fifo_arb.sv - DDR ring-buffer burst arbiter between a write and a read FIFO channel.
// Optional MEM_FIFO_ARB_RR_EN: round-robin tie-break; default build gives ties to read.
module mem_fifo_arb #(
  parameter int                   ADDR_BITS     = 24,
  parameter logic [9:0]           BURST_LEN     = 10'd64,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR     = '0,
  parameter logic [ADDR_BITS-1:0] REGION_WORDS  = ADDR_BITS'(4096),
  parameter logic [9:0]           RD_FIFO_DEPTH = 10'd512
) (
  input  logic                 mem_clk,
  input  logic                 rst_n,
  input  logic                 local_init_done,
  input  logic                 wr_ch_en,
  input  logic                 rd_ch_en,
  input  logic [9:0]           wr_fifo_rdusedw,
  input  logic [9:0]           rd_fifo_wrusedw,
  input  logic                 flush,
  output logic                 wr_burst_req,
  output logic                 rd_burst_req,
  output logic [9:0]           wr_burst_len,
  output logic [9:0]           rd_burst_len,
  output logic [ADDR_BITS-1:0] wr_burst_addr,
  output logic [ADDR_BITS-1:0] rd_burst_addr,
  input  logic                 wr_burst_finish,
  input  logic                 rd_burst_finish,
  output logic [ADDR_BITS:0]   ring_level,
  output logic                 busy
);

  localparam int LW = ADDR_BITS + 2;
  localparam logic [LW-1:0] L_BURST  = LW'(BURST_LEN);
  localparam logic [LW-1:0] L_REGION = LW'(REGION_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_WR_BURST, S_RD_BURST} state_t;

  state_t                 r_state;
  logic                   r_wr_req;
  logic                   r_rd_req;
  logic [ADDR_BITS-1:0]   r_wr_ptr;
  logic [ADDR_BITS-1:0]   r_rd_ptr;
  logic [ADDR_BITS:0]     r_ring_level;
  logic                   r_last_rd;
  logic                   r_flush_pend;

  logic [LW-1:0]          w_level;
  logic [LW-1:0]          w_wr_sum;
  logic [LW-1:0]          w_rd_sum;
  logic [ADDR_BITS-1:0]   w_wr_ptr_nxt;
  logic [ADDR_BITS-1:0]   w_rd_ptr_nxt;
  logic                   w_wr_ok;
  logic                   w_rd_ok;
  logic                   w_grant_wr;
  logic                   w_grant_rd;

  assign w_level  = LW'(r_ring_level);
  assign w_wr_sum = LW'(r_wr_ptr) + L_BURST;
  assign w_rd_sum = LW'(r_rd_ptr) + L_BURST;
  assign w_wr_ptr_nxt = ADDR_BITS'((w_wr_sum >= L_REGION) ? w_wr_sum - L_REGION : w_wr_sum);
  assign w_rd_ptr_nxt = ADDR_BITS'((w_rd_sum >= L_REGION) ? w_rd_sum - L_REGION : w_rd_sum);

  assign w_wr_ok = wr_ch_en && (wr_fifo_rdusedw >= BURST_LEN) && ((w_level + L_BURST) <= L_REGION);
  assign w_rd_ok = rd_ch_en && (w_level >= L_BURST) &&
                   (({1'b0, rd_fifo_wrusedw} + {1'b0, BURST_LEN}) <= {1'b0, RD_FIFO_DEPTH});

`ifdef MEM_FIFO_ARB_RR_EN
  assign w_grant_wr = w_wr_ok && (!w_rd_ok || r_last_rd);
`else
  assign w_grant_wr = w_wr_ok && !w_rd_ok;
`endif
  assign w_grant_rd = w_rd_ok && !w_grant_wr;

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wr_req     <= 1'b0;
      r_rd_req     <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_ring_level <= '0;
      r_last_rd    <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      r_wr_req <= 1'b0;
      r_rd_req <= 1'b0;
      if (!local_init_done) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_ARB;
          S_ARB: begin
            if (flush || r_flush_pend) begin
              r_wr_ptr     <= '0;
              r_rd_ptr     <= '0;
              r_ring_level <= '0;
              r_flush_pend <= 1'b0;
            end else if (w_grant_wr) begin
              r_state   <= S_WR_BURST;
              r_wr_req  <= 1'b1;
              r_last_rd <= 1'b0;
            end else if (w_grant_rd) begin
              r_state   <= S_RD_BURST;
              r_rd_req  <= 1'b1;
              r_last_rd <= 1'b1;
            end
          end
          // a flush seen mid-burst is remembered so a short pulse is not lost
          S_WR_BURST: begin
            if (flush) r_flush_pend <= 1'b1;
            if (wr_burst_finish) begin
              r_wr_ptr     <= w_wr_ptr_nxt;
              r_ring_level <= r_ring_level + (ADDR_BITS+1)'(BURST_LEN);
              r_state      <= S_ARB;
            end
          end
          S_RD_BURST: begin
            if (flush) r_flush_pend <= 1'b1;
            if (rd_burst_finish) begin
              r_rd_ptr     <= w_rd_ptr_nxt;
              r_ring_level <= r_ring_level - (ADDR_BITS+1)'(BURST_LEN);
              r_state      <= S_ARB;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign wr_burst_req  = r_wr_req;
  assign rd_burst_req  = r_rd_req;
  assign wr_burst_len  = BURST_LEN;
  assign rd_burst_len  = BURST_LEN;
  assign wr_burst_addr = BASE_ADDR + r_wr_ptr;
  assign rd_burst_addr = BASE_ADDR + r_rd_ptr;
  assign ring_level    = r_ring_level;
  assign busy          = (r_state == S_WR_BURST) || (r_state == S_RD_BURST);

endmodule

// File: tb/tb_mem_fifo_arb.sv
// tb/tb_mem_fifo_arb.sv - scoreboard bench for mem_fifo_arb (grant, address, ring level, flush, reset).
module tb_mem_fifo_arb;

  localparam int BL  = 64;
  localparam int RW  = 256;
  localparam int RDD = 512;

  logic        mem_clk = 1'b0;
  logic        rst_n;
  logic        local_init_done;
  logic        wr_ch_en, rd_ch_en;
  logic [9:0]  wr_fifo_rdusedw, rd_fifo_wrusedw;
  logic        flush;
  logic        wr_burst_req, rd_burst_req;
  logic [9:0]  wr_burst_len, rd_burst_len;
  logic [23:0] wr_burst_addr, rd_burst_addr;
  logic        wr_burst_finish, rd_burst_finish;
  logic [24:0] ring_level;
  logic        busy;

  mem_fifo_arb #(
    .ADDR_BITS(24), .BURST_LEN(10'd64), .BASE_ADDR(24'd0),
    .REGION_WORDS(24'd256), .RD_FIFO_DEPTH(10'd512)
  ) u_dut (
    .mem_clk(mem_clk), .rst_n(rst_n), .local_init_done(local_init_done),
    .wr_ch_en(wr_ch_en), .rd_ch_en(rd_ch_en),
    .wr_fifo_rdusedw(wr_fifo_rdusedw), .rd_fifo_wrusedw(rd_fifo_wrusedw),
    .flush(flush), .wr_burst_req(wr_burst_req), .rd_burst_req(rd_burst_req),
    .wr_burst_len(wr_burst_len), .rd_burst_len(rd_burst_len),
    .wr_burst_addr(wr_burst_addr), .rd_burst_addr(rd_burst_addr),
    .wr_burst_finish(wr_burst_finish), .rd_burst_finish(rd_burst_finish),
    .ring_level(ring_level), .busy(busy)
  );

  always #5 mem_clk = ~mem_clk;

  typedef struct packed {
    logic        is_wr;
    logic [23:0] addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_wr_ptr, m_rd_ptr, m_level;
  bit   m_last_rd;
  logic prev_wr = 1'b0, prev_rd = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge mem_clk) begin
    if (rst_n === 1'b1) begin
      if (wr_burst_req && rd_burst_req) check("dual_req", 32'(wr_burst_req & rd_burst_req), 0);
      if (wr_burst_req && prev_wr) check("wr_req_width", 32'(prev_wr), 0);
      if (rd_burst_req && prev_rd) check("rd_req_width", 32'(prev_rd), 0);
      if (wr_burst_req || rd_burst_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", 32'({wr_burst_req, rd_burst_req}), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("grant_is_wr", 32'(wr_burst_req), 32'(mon_e.is_wr));
          check("burst_addr", 32'(mon_e.is_wr ? wr_burst_addr : rd_burst_addr), 32'(mon_e.addr));
          check("burst_len", 32'(mon_e.is_wr ? wr_burst_len : rd_burst_len), BL);
        end
      end
    end
    prev_wr = wr_burst_req;
    prev_rd = rd_burst_req;
  end

  task automatic model_reset();
    m_wr_ptr = 0; m_rd_ptr = 0; m_level = 0; m_last_rd = 1'b0;
  endtask

  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge mem_clk);
      if (wr_burst_req || rd_burst_req) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("req_timeout", 0, 1);
  endtask

  task automatic predict(output bit g_wr, output bit any);
    bit ok_w, ok_r;
    ok_w = wr_ch_en && (int'(wr_fifo_rdusedw) >= BL) && (m_level + BL <= RW);
    ok_r = rd_ch_en && (m_level >= BL) && (int'(rd_fifo_wrusedw) + BL <= RDD);
    any  = ok_w || ok_r;
`ifdef MEM_FIFO_ARB_RR_EN
    g_wr = ok_w && (!ok_r || m_last_rd);
`else
    g_wr = ok_w && !ok_r;
`endif
  endtask

  task automatic run_burst(input bit flush_mid);
    bit g_wr, any, seen, got_wr;
    int e_addr;
    predict(g_wr, any);
    e_addr = g_wr ? m_wr_ptr : m_rd_ptr;
    exp_q.push_back({g_wr, 24'(e_addr)});
    wait_req(seen);
    if (!seen) return;
    got_wr = wr_burst_req;
    check("busy_on_req", 32'(busy), 1);
    if (flush_mid) begin
      wr_ch_en = 1'b0;
      flush = 1'b1;
    end
    if (got_wr) rd_burst_finish = 1'b1; else wr_burst_finish = 1'b1;
    @(negedge mem_clk);
    flush = 1'b0;
    rd_burst_finish = 1'b0;
    wr_burst_finish = 1'b0;
    check("busy_hold", 32'(busy), 1);
    check("level_hold", 32'(ring_level), m_level);
    check("addr_hold", 32'(got_wr ? wr_burst_addr : rd_burst_addr), e_addr);
    if (got_wr) wr_burst_finish = 1'b1; else rd_burst_finish = 1'b1;
    @(negedge mem_clk);
    wr_burst_finish = 1'b0;
    rd_burst_finish = 1'b0;
    if (g_wr) begin
      m_wr_ptr = (m_wr_ptr + BL) % RW; m_level += BL; m_last_rd = 1'b0;
    end else begin
      m_rd_ptr = (m_rd_ptr + BL) % RW; m_level -= BL; m_last_rd = 1'b1;
    end
    check("busy_after_finish", 32'(busy), 0);
    check("level_after_finish", 32'(ring_level), m_level);
    check("wr_addr_after", 32'(wr_burst_addr), m_wr_ptr);
    check("rd_addr_after", 32'(rd_burst_addr), m_rd_ptr);
    if (flush_mid) begin
      @(negedge mem_clk);
      model_reset();
      check("flush_level", 32'(ring_level), 0);
      check("flush_wr_addr", 32'(wr_burst_addr), 0);
      check("flush_rd_addr", 32'(rd_burst_addr), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    rst_n = 1'b0; local_init_done = 1'b0; wr_ch_en = 1'b0; rd_ch_en = 1'b0;
    wr_fifo_rdusedw = '0; rd_fifo_wrusedw = '0; flush = 1'b0;
    wr_burst_finish = 1'b0; rd_burst_finish = 1'b0;
    model_reset();
    @(negedge mem_clk);
    check("rst_wr_req", 32'(wr_burst_req), 0);
    check("rst_rd_req", 32'(rd_burst_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_level", 32'(ring_level), 0);
    check("rst_wr_addr", 32'(wr_burst_addr), 0);
    check("rst_rd_addr", 32'(rd_burst_addr), 0);

    // calibration not done: eligible write must stay idle
    rst_n = 1'b1; wr_ch_en = 1'b1; wr_fifo_rdusedw = 10'd64;
    repeat (5) @(negedge mem_clk);
    check("no_init_busy", 32'(busy), 0);

    // fill the ring with four writes, then it must stop
    local_init_done = 1'b1;
    repeat (4) run_burst(1'b0);
    repeat (10) @(negedge mem_clk);
    check("full_level", 32'(ring_level), 256);
    check("full_wr_wrap", 32'(wr_burst_addr), 0);
    check("full_busy", 32'(busy), 0);

    // both channels eligible: tie-break order
    rd_ch_en = 1'b1;
    repeat (6) run_burst(1'b0);

    // make room, then flush in the middle of a write burst
    wr_ch_en = 1'b0;
    while (m_level + BL > RW) run_burst(1'b0);
    rd_ch_en = 1'b0; wr_ch_en = 1'b1;
    run_burst(1'b1);
    repeat (5) @(negedge mem_clk);

    // held flush beats an eligible write
    flush = 1'b1; wr_ch_en = 1'b1;
    repeat (6) @(negedge mem_clk);
    check("flush_blocks_grant", 32'(busy), 0);
    flush = 1'b0;
    run_burst(1'b0);

    // read FIFO headroom boundary
    wr_ch_en = 1'b0; rd_ch_en = 1'b1; rd_fifo_wrusedw = 10'd460;
    repeat (10) @(negedge mem_clk);
    check("rd_full_busy", 32'(busy), 0);
    check("rd_full_level", 32'(ring_level), 64);
    rd_fifo_wrusedw = 10'd448;
    run_burst(1'b0);

    // asynchronous reset in the middle of a burst
    rd_ch_en = 1'b0; wr_ch_en = 1'b1;
    exp_q.push_back({1'b1, 24'(m_wr_ptr)});
    wait_req(seen);
    #1 rst_n = 1'b0;
    #1;
    check("arst_wr_req", 32'(wr_burst_req), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_level", 32'(ring_level), 0);
    local_init_done = 1'b0;
    @(negedge mem_clk);
    rst_n = 1'b1;
    repeat (5) @(negedge mem_clk);
    check("post_rst_busy", 32'(busy), 0);
    model_reset();
    local_init_done = 1'b1;
    run_burst(1'b0);
    wr_ch_en = 1'b0;
    repeat (3) @(negedge mem_clk);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
